fetch_sequencer: RTL and testbench

Front-end fetch sequencer: the producer side of the program-counter interface. Every cycle it computes `pcNext` for the PC register from the current `pc`, decode back-pressure and execute-stage redirects. It pairs `pc` with the instruction-memory word and presents the pair to decode through a registered valid/ready output stage. It sits between the PC register, instruction memory and decode in the RISCV top.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_sequencer_buffer.sv | 44 ++++
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RISC-V front end.
package riscv_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BITS   = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/fetch_sequencer_buffer.sv
// One-entry registered decode slot holding an {instr, pc} pair.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int PC_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic                  i_ready,
  input  logic [INSTR_BITS-1:0] i_instr,
  input  logic [PC_BITS-1:0]    i_pc,
  output logic                  o_valid,
  output logic                  o_free,
  output logic [INSTR_BITS-1:0] o_instr,
  output logic [PC_BITS-1:0]    o_pc
);
  logic                  r_valid;
  logic [INSTR_BITS-1:0] r_instr;
  logic [PC_BITS-1:0]    r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Free when empty, or when decode drains the slot this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: next-PC mux, redirect/fault FSM and decode slot.
//   state | meaning
//   EMPTY | slot empty
//   FULL  | slot holds an instruction
//   FAULT | stopped after a misaligned redirect, only rst exits
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int                  REG_BITS     = 32,
  parameter logic [REG_BITS-1:0] RESET_VECTOR = REG_BITS'(riscv_pkg::RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_BITS-1:0]   pc,
  output logic [REG_BITS-1:0]   pcNext,
  input  logic [INSTR_BITS-1:0] instrRD,
  output logic                  fetchValid,
  input  logic                  fetchReady,
  output logic [INSTR_BITS-1:0] fetchInstr,
  output logic [REG_BITS-1:0]   fetchPc,
  input  logic                  redirValid,
  input  logic [REG_BITS-1:0]   redirTarget,
  output logic                  redirReady,
  output logic                  fault,
  output logic [REG_BITS-1:0]   faultPc
);
  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [REG_BITS-1:0] r_fault_pc;
  logic                w_load;
  logic                w_flush;
  logic                w_fault_load;
  logic                w_slot_free;
  logic                w_slot_valid;
  logic                w_redir_acc;
  logic                w_misaligned;

  fetch_buffer #(
    .PC_BITS (REG_BITS)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_ready (fetchReady),
    .i_instr (instrRD),
    .i_pc    (pc),
    .o_valid (w_slot_valid),
    .o_free  (w_slot_free),
    .o_instr (fetchInstr),
    .o_pc    (fetchPc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_fault_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fault_load) r_fault_pc <= redirTarget;
    end
  end

  assign redirReady   = (r_state != FAULT);
  assign w_redir_acc  = redirValid && redirReady;
  assign w_misaligned = (redirTarget[1:0] != 2'b00);

  always_comb begin
    w_state_nxt  = r_state;
    pcNext       = pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_fault_load = 1'b0;
    if (rst) begin
      pcNext = RESET_VECTOR;
    end else if (r_state != FAULT) begin
      if (w_redir_acc) begin
        // Redirect beats fetch and stall; the word at pc is dropped.
        w_flush = 1'b1;
        if (w_misaligned) begin
          w_state_nxt  = FAULT;
          w_fault_load = 1'b1;
        end else begin
          w_state_nxt = EMPTY;
          pcNext      = redirTarget;
        end
      end else if (r_state == EMPTY || w_slot_free) begin
        w_load      = 1'b1;
        w_state_nxt = FULL;
        pcNext      = pc + REG_BITS'(PC_STEP);
      end
    end
  end

  assign fetchValid = (r_state == FULL) && w_slot_valid;
  assign fault      = (r_state == FAULT);
  assign faultPc    = r_fault_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a local PC register and memory model.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] instrRD;
  logic        fetchValid;
  logic        fetchReady;
  logic [31:0] fetchInstr;
  logic [31:0] fetchPc;
  logic        redirValid;
  logic [31:0] redirTarget;
  logic        redirReady;
  logic        fault;
  logic [31:0] faultPc;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else     pc <= pcNext;
  end

  assign instrRD = mem(pc);

  fetch_sequencer #(
    .REG_BITS     (32),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pcNext      (pcNext),
    .instrRD     (instrRD),
    .fetchValid  (fetchValid),
    .fetchReady  (fetchReady),
    .fetchInstr  (fetchInstr),
    .fetchPc     (fetchPc),
    .redirValid  (redirValid),
    .redirTarget (redirTarget),
    .redirReady  (redirReady),
    .fault       (fault),
    .faultPc     (faultPc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetchReady = 1'b1; redirValid = 1'b0; redirTarget = 32'h0;
    tick(); tick();
    #1;
    chk("rst_pcNext", pcNext, 32'h0);
    chk("rst_valid", fetchValid, 0);
    chk("rst_instr", fetchInstr, 32'h0);
    chk("rst_fpc", fetchPc, 32'h0);
    chk("rst_fault", fault, 0);
    chk("rst_faultPc", faultPc, 32'h0);
    chk("rst_redirReady", redirReady, 1);

    // Stream from reset vector
    rst = 1'b0; #1;
    chk("s0_pcNext", pcNext, 32'd4);
    tick(); #1;
    chk("s1_pcNext", pcNext, 32'd8);
    chk("s1_valid", fetchValid, 1);
    chk("s1_fpc", fetchPc, 32'd0);
    chk("s1_instr", fetchInstr, 32'hDEAD_0013);
    tick(); #1;
    chk("s2_pcNext", pcNext, 32'd12);
    chk("s2_fpc", fetchPc, 32'd4);
    chk("s2_instr", fetchInstr, 32'hDEAD_0017);
    tick(); #1;
    chk("s3_fpc", fetchPc, 32'd8);
    chk("s3_instr", fetchInstr, 32'hDEAD_001B);

    // Stall three cycles at fetchPc = 8
    fetchReady = 1'b0; #1;
    chk("st_pcNext", pcNext, 32'd12);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("st_pc", pc, 32'd12);
      chk("st_pcNext_h", pcNext, 32'd12);
      chk("st_fpc", fetchPc, 32'd8);
      chk("st_instr", fetchInstr, 32'hDEAD_001B);
      chk("st_valid", fetchValid, 1);
    end
    fetchReady = 1'b1; #1;
    chk("res_pcNext", pcNext, 32'd16);
    tick(); #1;
    chk("res_fpc", fetchPc, 32'd12);
    chk("res_instr", fetchInstr, 32'hDEAD_001F);

    // Redirect while stalled drops held instruction
    fetchReady = 1'b0; redirValid = 1'b1; redirTarget = 32'h100; #1;
    chk("rd_ready", redirReady, 1);
    chk("rd_pcNext", pcNext, 32'h100);
    tick();
    redirValid = 1'b0; fetchReady = 1'b1; #1;
    chk("rd_valid0", fetchValid, 0);
    chk("rd_pc", pc, 32'h100);
    chk("rd_pcNext2", pcNext, 32'h104);
    tick(); #1;
    chk("rd_valid1", fetchValid, 1);
    chk("rd_fpc", fetchPc, 32'h100);
    chk("rd_instr", fetchInstr, 32'hDEAD_0113);

    // Redirect concurrent with handshake
    redirValid = 1'b1; redirTarget = 32'h200; #1;
    chk("rh_pcNext", pcNext, 32'h200);
    tick();
    redirValid = 1'b0; #1;
    chk("rh_valid0", fetchValid, 0);
    chk("rh_pc", pc, 32'h200);
    tick(); #1;
    chk("rh_fpc", fetchPc, 32'h200);

    // Wrap at top of address space
    redirValid = 1'b1; redirTarget = 32'hFFFF_FFFC;
    tick();
    redirValid = 1'b0; #1;
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    chk("wr_pcNext", pcNext, 32'h0);
    tick(); #1;
    chk("wr_fpc", fetchPc, 32'hFFFF_FFFC);
    chk("wr_fault", fault, 0);
    chk("wr_pc0", pc, 32'h0);
    tick(); #1;
    // pc is now 4

    // Misaligned redirect
    redirValid = 1'b1; redirTarget = 32'h102; #1;
    chk("mf_ready", redirReady, 1);
    chk("mf_pcNext", pcNext, 32'd4);
    tick(); #1;
    chk("mf_fault", fault, 1);
    chk("mf_faultPc", faultPc, 32'h102);
    chk("mf_valid", fetchValid, 0);
    chk("mf_ready0", redirReady, 0);
    chk("mf_pc", pc, 32'd4);
    redirTarget = 32'h300; fetchReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("fz_pc", pc, 32'd4);
      chk("fz_pcNext", pcNext, 32'd4);
      chk("fz_fault", fault, 1);
      chk("fz_faultPc", faultPc, 32'h102);
      chk("fz_valid", fetchValid, 0);
    end
    redirValid = 1'b0;

    // Reset exits FAULT
    rst = 1'b1; #1;
    chk("fr_fault", fault, 0);
    chk("fr_faultPc", faultPc, 32'h0);
    chk("fr_pcNext", pcNext, 32'h0);
    rst = 1'b0;
    tick(); #1;
    chk("fr_fpc", fetchPc, 32'h0);
    chk("fr_valid", fetchValid, 1);
    tick(); #1;
    chk("fr_fpc2", fetchPc, 32'd4);
    tick(); #1;

    // 1 ns reset pulse while FULL
    chk("rp_pre_valid", fetchValid, 1);
    rst = 1'b1; #1;
    chk("rp_valid", fetchValid, 0);
    chk("rp_fpc", fetchPc, 32'h0);
    chk("rp_instr", fetchInstr, 32'h0);
    chk("rp_pcNext", pcNext, 32'h0);
    chk("rp_pc", pc, 32'h0);
    rst = 1'b0;
    tick(); #1;
    chk("rp_fpc0", fetchPc, 32'h0);
    chk("rp_instr0", fetchInstr, 32'hDEAD_0013);
    tick(); #1;
    chk("rp_fpc1", fetchPc, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
